// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning path.
//
// Contents:
//   rpt_state_e          per-channel auto-repeat state (UP, HOLD, REPEAT)
//   DEBOUNCE_20MS        20 ms of stable level at 50 MHz
//   REPEAT_DELAY_500MS   hold time before the first auto-repeat at 50 MHz
//   REPEAT_PERIOD_100MS  spacing of subsequent auto-repeats at 50 MHz
//   cnt_width()          counter width for a count of n states (never 0)
//   max_int()            larger of two integers, for sizing shared counters
package key_pkg;

  typedef enum logic [1:0] {
    UP     = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEBOUNCE_20MS       = 1000000;
  localparam int REPEAT_DELAY_500MS  = 25000000;
  localparam int REPEAT_PERIOD_100MS = 5000000;

  // A counter that runs 0..n-1 needs $clog2(n) bits; keep at least one bit
  // so degenerate parameter values still elaborate.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Bundle between the raw DE1 KEY pins and the downstream counter/display
// logic.
//
// Signals:
//   key_n          raw asynchronous keys, 0 = pressed (into the conditioner)
//   key_down       debounced level, 1 = pressed
//   press_pulse    1-cycle strobe on an accepted press
//   release_pulse  1-cycle strobe on an accepted release
//   repeat_pulse   1-cycle strobe per auto-repeat while held
//   rpt_state      per-channel repeat FSM state (debug visibility)
//
// Handshake: there is no valid/ready pair. Every strobe is a single-cycle,
// fire-and-forget event with no backpressure; a consumer must act on it in
// the cycle it is high. key_down is a level and may be sampled at any time.
//
// Modports:
//   slave   the conditioner (consumes key_n, produces everything else)
//   master  the upstream/consumer side (drives key_n, observes the rest)
interface key_conditioner_if #(
  parameter int NUM_KEYS = 4
);

  logic [NUM_KEYS-1:0]      key_n;
  logic [NUM_KEYS-1:0]      key_down;
  logic [NUM_KEYS-1:0]      press_pulse;
  logic [NUM_KEYS-1:0]      release_pulse;
  logic [NUM_KEYS-1:0]      repeat_pulse;
  logic [NUM_KEYS-1:0][1:0] rpt_state;

  modport slave (
    input  key_n,
    output key_down,
    output press_pulse,
    output release_pulse,
    output repeat_pulse,
    output rpt_state
  );

  modport master (
    output key_n,
    input  key_down,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse,
    input  rpt_state
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, stability filter and auto-repeat FSM.
//
// Ports:
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_key_n         raw key, 0 = pressed
//   o_key_down      debounced level, 1 = pressed
//   o_press         1-cycle strobe, same cycle o_key_down rises
//   o_release       1-cycle strobe, same cycle o_key_down falls
//   o_repeat        1-cycle auto-repeat strobe while held
//   o_state         repeat FSM state (debug)
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_n,
  output logic       o_key_down,
  output logic       o_press,
  output logic       o_release,
  output logic       o_repeat,
  output rpt_state_e o_state
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  // Synchroniser holds the raw active-low level; reset to 1 = released.
  logic r_sync1;
  logic r_sync2;
  logic w_sync;

  logic [DW-1:0] r_stable_cnt;
  logic          r_key_down;
  logic          r_press;
  logic          r_release;
  logic          w_differ;
  logic          w_accept;
  logic          w_accept_press;
  logic          w_accept_release;

  rpt_state_e    r_state;
  rpt_state_e    w_state_nxt;
  logic [RW-1:0] r_rpt_cnt;
  logic [RW-1:0] w_rpt_cnt_nxt;
  logic          r_repeat;
  logic          w_repeat_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync   = ~r_sync2;
  assign w_differ = (w_sync != r_key_down);
  // The level flips only after DEBOUNCE_CYCLES consecutive mismatching
  // samples: the counter has seen DEBOUNCE_CYCLES-1 of them and this cycle
  // still mismatches.
  assign w_accept         = w_differ && (r_stable_cnt == DB_LAST);
  assign w_accept_press   = w_accept && !r_key_down;
  assign w_accept_release = w_accept && r_key_down;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable_cnt <= '0;
      r_key_down   <= 1'b0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
    end else begin
      if (!w_differ || w_accept) begin
        r_stable_cnt <= '0;
      end else begin
        r_stable_cnt <= r_stable_cnt + DW'(1);
      end
      if (w_accept) begin
        r_key_down <= ~r_key_down;
      end
      r_press   <= w_accept_press;
      r_release <= w_accept_release;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= UP;
      r_rpt_cnt <= '0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rpt_cnt <= w_rpt_cnt_nxt;
      r_repeat  <= w_repeat_nxt;
    end
  end

  // A release accepted on the same edge as a repeat terminal count wins:
  // the channel returns to UP and that repeat is dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_rpt_cnt_nxt = r_rpt_cnt;
    w_repeat_nxt  = 1'b0;
    case (r_state)
      UP: begin
        w_rpt_cnt_nxt = '0;
        if (w_accept_press) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_accept_release) begin
          w_state_nxt   = UP;
          w_rpt_cnt_nxt = '0;
        end else if (r_rpt_cnt == DELAY_LAST) begin
          w_state_nxt   = REPEAT;
          w_rpt_cnt_nxt = '0;
          w_repeat_nxt  = 1'b1;
        end else begin
          w_rpt_cnt_nxt = r_rpt_cnt + RW'(1);
        end
      end
      REPEAT: begin
        if (w_accept_release) begin
          w_state_nxt   = UP;
          w_rpt_cnt_nxt = '0;
        end else if (r_rpt_cnt == PERIOD_LAST) begin
          w_rpt_cnt_nxt = '0;
          w_repeat_nxt  = 1'b1;
        end else begin
          w_rpt_cnt_nxt = r_rpt_cnt + RW'(1);
        end
      end
      default: begin
        w_state_nxt   = UP;
        w_rpt_cnt_nxt = '0;
      end
    endcase
    if (REPEAT_EN == 0) begin
      w_state_nxt   = UP;
      w_rpt_cnt_nxt = '0;
      w_repeat_nxt  = 1'b0;
    end
  end

  assign o_key_down = r_key_down;
  assign o_press    = r_press;
  assign o_release  = r_release;
  assign o_repeat   = r_repeat;
  assign o_state    = r_state;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner for the DE1 KEY inputs: one independent
// synchronise/debounce/auto-repeat channel per key, outputs packed into
// vectors on the bus interface.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; clears every channel at once
//   bus    key_conditioner_if.slave (key_n in; key_down, press_pulse,
//          release_pulse, repeat_pulse, rpt_state out)
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input logic               clk,
  input logic               rst_n,
  key_conditioner_if.slave  bus
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    rpt_state_e w_state;

    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_key_n    (bus.key_n[g]),
      .o_key_down (bus.key_down[g]),
      .o_press    (bus.press_pulse[g]),
      .o_release  (bus.release_pulse[g]),
      .o_repeat   (bus.repeat_pulse[g]),
      .o_state    (w_state)
    );

    assign bus.rpt_state[g] = w_state;
  end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;

  int total = 0;
  int bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  key_conditioner_if #(.NUM_KEYS(NK)) bus_a ();
  key_conditioner_if #(.NUM_KEYS(NK)) bus_b ();

  assign bus_a.key_n = key_n;
  assign bus_b.key_n = key_n;

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // ---------------- checker ----------------
  task automatic chk(input string what, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", what, idx, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Behavioural view: the key level seen by the filter is the raw key two
  // edges late; the debounced level flips once the last DB samples all
  // disagree with it; repeats fall at RD, RD+RP, RD+2RP... edges after press.
  logic [15:0] exp_q[$];
  logic [15:0] exp_b_q[$];
  logic m_p1 [NK];
  logic m_p2 [NK];
  logic m_kd [NK];
  logic m_hist [NK][$];
  int   m_t_press [NK];
  int   m_cyc = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic s;
    logic all_diff;
    int held;
    logic [NK-1:0] kd_v, pr_v, rl_v, rp_v;
    if (!rst_n) begin
      for (int c = 0; c < NK; c++) begin
        m_p1[c] = 1'b1;
        m_p2[c] = 1'b1;
        m_kd[c] = 1'b0;
        m_hist[c].delete();
        m_t_press[c] = 0;
      end
      exp_q.delete();
      exp_b_q.delete();
    end else begin
      m_cyc++;
      kd_v = '0; pr_v = '0; rl_v = '0; rp_v = '0;
      for (int c = 0; c < NK; c++) begin
        s = ~m_p2[c];
        m_p2[c] = m_p1[c];
        m_p1[c] = key_n[c];
        m_hist[c].push_back(s);
        if (m_hist[c].size() > DB) void'(m_hist[c].pop_front());
        if (m_hist[c].size() == DB) begin
          all_diff = 1'b1;
          for (int k = 0; k < DB; k++)
            if (m_hist[c][k] == m_kd[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_kd[c] = ~m_kd[c];
            m_hist[c].delete();
            if (m_kd[c]) begin
              pr_v[c] = 1'b1;
              m_t_press[c] = m_cyc;
            end else begin
              rl_v[c] = 1'b1;
            end
          end
        end
        if (m_kd[c] && !pr_v[c]) begin
          held = m_cyc - m_t_press[c];
          if (held >= RD && ((held - RD) % RP) == 0) rp_v[c] = 1'b1;
        end
        kd_v[c] = m_kd[c];
      end
      exp_q.push_back({kd_v, pr_v, rl_v, rp_v});
      exp_b_q.push_back({kd_v, pr_v, rl_v, 4'b0000});
    end
  end

  always @(negedge clk) begin : scoreboard
    logic [15:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("model_a", m_cyc,
          {16'h0, bus_a.key_down, bus_a.press_pulse, bus_a.release_pulse, bus_a.repeat_pulse},
          {16'h0, e});
    end
    if (rst_n && exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      chk("model_b", m_cyc,
          {16'h0, bus_b.key_down, bus_b.press_pulse, bus_b.release_pulse, bus_b.repeat_pulse},
          {16'h0, e});
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [NK-1:0] key_n;
    int            hold;
    logic [NK-1:0] exp_down;
    int            exp_press;
    int            exp_rel;
    int            exp_rep;
    logic [NK-1:0] exp_press_last;
  } step_t;

  // Called at a falling edge: applies key_n, runs hold cycles, counts strobes.
  task automatic run_step(input int idx, input step_t s);
    int pa, ra, qa, pb, rb, qb;
    logic [NK-1:0] last;
    pa = 0; ra = 0; qa = 0; pb = 0; rb = 0; qb = 0; last = '0;
    key_n = s.key_n;
    repeat (s.hold) begin
      @(posedge clk);
      @(negedge clk);
      pa += $countones(bus_a.press_pulse);
      ra += $countones(bus_a.release_pulse);
      qa += $countones(bus_a.repeat_pulse);
      pb += $countones(bus_b.press_pulse);
      rb += $countones(bus_b.release_pulse);
      qb += $countones(bus_b.repeat_pulse);
      last = bus_a.press_pulse;
    end
    chk("step_down_a", idx, 32'(bus_a.key_down), 32'(s.exp_down));
    chk("step_down_b", idx, 32'(bus_b.key_down), 32'(s.exp_down));
    chk("step_press_a", idx, pa, s.exp_press);
    chk("step_rel_a", idx, ra, s.exp_rel);
    chk("step_rep_a", idx, qa, s.exp_rep);
    chk("step_press_last", idx, 32'(last), 32'(s.exp_press_last));
    chk("step_press_b", idx, pb, s.exp_press);
    chk("step_rel_b", idx, rb, s.exp_rel);
    chk("step_rep_b", idx, qb, 0);
  endtask

  step_t steps[$];
  step_t s;
  int rates[4] = '{2, 5, 15, 40};

  initial begin
    // reset held with keys released
    key_n = '1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_down", 0, 32'(bus_a.key_down), 0);
    chk("rst_press", 0, 32'(bus_a.press_pulse), 0);
    chk("rst_rel", 0, 32'(bus_a.release_pulse), 0);
    chk("rst_rep", 0, 32'(bus_a.repeat_pulse), 0);
    chk("rst_state", 0, 32'(bus_a.rpt_state), 0);
    rst_n = 1'b1;

    //                 key_n hold down pr rl rp last
    steps.push_back('{4'hF, 20, 4'h0, 0, 0, 0, 4'h0}); // 0 idle after reset
    steps.push_back('{4'hE,  5, 4'h0, 0, 0, 0, 4'h0}); // 1 key0 not yet
    steps.push_back('{4'hE,  1, 4'h1, 1, 0, 0, 4'h1}); // 2 key0 accepted at +6
    steps.push_back('{4'hF,  5, 4'h1, 0, 0, 0, 4'h0}); // 3
    steps.push_back('{4'hF,  1, 4'h0, 0, 1, 0, 4'h0}); // 4 release at +6
    steps.push_back('{4'hD,  2, 4'h0, 0, 0, 0, 4'h0}); // 5 bounce key1
    steps.push_back('{4'hF,  2, 4'h0, 0, 0, 0, 4'h0}); // 6
    steps.push_back('{4'hD,  2, 4'h0, 0, 0, 0, 4'h0}); // 7
    steps.push_back('{4'hF,  2, 4'h0, 0, 0, 0, 4'h0}); // 8
    steps.push_back('{4'hD,  5, 4'h0, 0, 0, 0, 4'h0}); // 9 final edge
    steps.push_back('{4'hD,  1, 4'h2, 1, 0, 0, 4'h2}); // 10 press +6
    steps.push_back('{4'hF,  6, 4'h0, 0, 1, 0, 4'h0}); // 11
    steps.push_back('{4'hB,  6, 4'h4, 1, 0, 0, 4'h4}); // 12 key2 press at P
    steps.push_back('{4'hB, 32, 4'h4, 0, 0, 9, 4'h0}); // 13 repeats P+8..P+32
    steps.push_back('{4'hF,  5, 4'h4, 0, 0, 1, 4'h0}); // 14 repeat P+35
    steps.push_back('{4'hF,  1, 4'h0, 0, 1, 0, 4'h0}); // 15 release at P+38 masks repeat
    steps.push_back('{4'hF, 10, 4'h0, 0, 0, 0, 4'h0}); // 16 quiet after release
    steps.push_back('{4'h6,  5, 4'h0, 0, 0, 0, 4'h0}); // 17 key0+key3
    steps.push_back('{4'h6,  1, 4'h9, 2, 0, 0, 4'h9}); // 18 simultaneous press
    steps.push_back('{4'hF,  6, 4'h0, 0, 2, 0, 4'h0}); // 19
    steps.push_back('{4'h7,  3, 4'h0, 0, 0, 0, 4'h0}); // 20 3-cycle glitch key3
    steps.push_back('{4'hF, 10, 4'h0, 0, 0, 0, 4'h0}); // 21 no activity
    steps.push_back('{4'hE,  6, 4'h1, 1, 0, 0, 4'h1}); // 22 key0 down for reset test

    for (int i = 0; i < steps.size(); i++) begin
      run_step(i, steps[i]);
      if (i == 13) begin
        chk("state_a_ch2", i, 32'(bus_a.rpt_state[2]), 2);
        chk("state_b_ch2", i, 32'(bus_b.rpt_state[2]), 0);
      end
    end

    // asynchronous reset mid-cycle with key0 still held
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_down_a", 0, 32'(bus_a.key_down), 0);
    chk("async_down_b", 0, 32'(bus_b.key_down), 0);
    chk("async_press", 0, 32'(bus_a.press_pulse), 0);
    chk("async_rel", 0, 32'(bus_a.release_pulse), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s = '{4'hE, 5, 4'h0, 0, 0, 0, 4'h0}; run_step(100, s);
    s = '{4'hE, 1, 4'h1, 1, 0, 0, 4'h1}; run_step(101, s);
    s = '{4'hF, 6, 4'h0, 0, 1, 0, 4'h0}; run_step(102, s);

    // randomized traffic, checked by the model scoreboard
    for (int seg = 0; seg < 20; seg++) begin
      int rate;
      rate = rates[$urandom_range(0, 3)];
      for (int k = 0; k < 100; k++) begin
        for (int c = 0; c < NK; c++)
          if ($urandom_range(0, rate - 1) == 0) key_n[c] = ~key_n[c];
        if (seg == 10 && k == 50) begin
          @(posedge clk);
          #3 rst_n = 1'b0;
          @(negedge clk);
          @(negedge clk);
          rst_n = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
      end
    end

    key_n = '1;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Upstream conditioning stage for the DE1 push-buttons (active-low KEY inputs).
- Synchronises each raw key to clk and debounces it.
- Produces a clean active-high "down" level plus single-cycle press, release and auto-repeat strobes.
- Downstream logic (counter/display stage) steps on these strobes instead of using KEY as a clock.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a new level (20 ms at 50 MHz); legal range ≥2.
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = repeat_pulse tied 0.
- REPEAT_DELAY, 25000000, cycles key must stay down after the press pulse before the first repeat.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeats.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_n  in  NUM_KEYS  raw asynchronous keys, 0 = pressed.
- key_down  out  NUM_KEYS  debounced level, 1 = pressed.
- press_pulse  out  NUM_KEYS  1-cycle strobe on accepted press.
- release_pulse  out  NUM_KEYS  1-cycle strobe on accepted release.
- repeat_pulse  out  NUM_KEYS  1-cycle strobe per auto-repeat while held.

Behaviour:
- Reset: one clk; reset is asynchronous and active-low (rst_n). Asserting rst_n=0 clears all state immediately, regardless of clk.
- Reset values: synchroniser FFs = 1 (released); key_down = 0; all pulses = 0; counters = 0; FSM = UP.
- Synchroniser: 2-flop chain per key. sync = ~key_n after 2 clks.
- Debounce filter, per channel:
  - stable_cnt resets to 0 whenever sync == key_down.
  - Otherwise stable_cnt increments each clk.
  - When stable_cnt reaches DEBOUNCE_CYCLES-1 while sync still differs, key_down toggles on the next edge and stable_cnt clears.
  - Any mismatch-free cycle (bounce back) restarts the count from 0.
- Latency: a clean input edge changes key_down exactly 2+DEBOUNCE_CYCLES clk edges later. Glitches shorter than DEBOUNCE_CYCLES never reach key_down.
- Pulses: registered, asserted in the same cycle key_down changes.
  - press_pulse on 0->1; release_pulse on 1->0.
  - Never both in one cycle on one channel.
- Repeat FSM, per channel; states UP, HOLD, REPEAT; rpt_cnt sized for max(REPEAT_DELAY, REPEAT_PERIOD).
  - UP: on accepted press -> HOLD, rpt_cnt = 0.
  - HOLD: rpt_cnt increments. At REPEAT_DELAY-1: emit repeat_pulse, rpt_cnt = 0, -> REPEAT.
  - REPEAT: rpt_cnt increments. At REPEAT_PERIOD-1: emit repeat_pulse, rpt_cnt = 0.
  - Accepted release in HOLD or REPEAT -> UP the same cycle release_pulse fires. No repeat_pulse in that cycle.
  - REPEAT_EN=0: FSM held in UP.
- Channels are fully independent; simultaneous presses on several keys give simultaneous pulses.
- Reset mid-press: all outputs drop to 0 with no release_pulse. After reset, a key still held is re-accepted as a fresh press after 2+DEBOUNCE_CYCLES cycles.
- Counter widths: $clog2 of the relevant parameter. No wrap is possible, since counters clear at terminal count.

Decomposition:
- Package key_pkg:
  - repeat state enum (UP, HOLD, REPEAT).
  - default timing constants for 50 MHz (DEBOUNCE_20MS, REPEAT_DELAY_500MS, REPEAT_PERIOD_100MS).
- Sub-module key_debounce_ch:
  - one channel: synchroniser + filter + repeat FSM, scalar ports.
  - Top generates NUM_KEYS instances and packs the output vectors.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, NUM_KEYS=4):
- Reset held then released, key_n=4'hF -> key_down=0, all pulses 0 for 20 cycles; rst_n=0 asynchronously mid-cycle clears a set key_down immediately.
- key_n[0] 1->0 clean at cycle 0 -> key_down[0]=1 and press_pulse[0]=1 at cycle 6 only, for exactly 1 cycle; other channels unchanged.
- key_n[1] bounces 0,1,0,1 with 2-cycle widths, then stays 0 -> no pulse during bounce; press_pulse[1] exactly 6 cycles after the final edge.
- key_n[2] held low 30 cycles after acceptance -> repeat_pulse[2] at +8, +11, +14, ... after press_pulse; release then gives release_pulse[2] 6 cycles after the edge and no further repeats.
- key_n[0] and key_n[3] pressed in the same cycle -> press_pulse=4'b1001 in one cycle; a 3-cycle low glitch on key_n[3] while released -> no output activity.
- REPEAT_EN=0 rebuild, key held 30 cycles -> repeat_pulse stays 0; press/release pulses still correct.
